bit_serial_alu_seq: RTL and testbench

- Word-level sequencer that sits directly upstream of the team's 1-bit ALU slice (ports a, b, c_in, operation[2:0] -> result, c_out).
- Accepts two WIDTH-bit operands and a 3-bit operation code.
- Streams the operands LSB-first through the external slice, one bit per clock, chaining the slice carry between bits.
- Reassembles the WIDTH-bit result and final carry-out and presents them to the datapath with a done pulse.

---
 rtl/bit_serial_alu_seq.sv | 102 ++++++++++
 tb/tb_bit_serial_alu_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_seq.sv
// Word-level sequencer that feeds an external 1-bit ALU slice LSB-first,
// chains the slice carry between bits and reassembles the WIDTH-bit result.
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_init,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_c_in,
  output logic [2:0]       slice_op,
  input  logic             slice_result,
  input  logic             slice_c_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             c_out
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [2:0]       op_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt;
  logic             shifting, last_bit;

  assign shifting = (state == SHIFT);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Written as shift-then-insert so WIDTH=1 needs no special slice.
  always_comb begin
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = slice_result;
  end

  // Slice drive comes only from registers; nothing loops back from the slice.
  assign slice_a    = shifting & a_sr[0];
  assign slice_b    = shifting & b_sr[0];
  assign slice_c_in = shifting & carry_r;
  assign slice_op   = shifting ? op_r : 3'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      op_r    <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      y       <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            op_r    <= op;
            carry_r <= carry_init;
            cnt     <= '0;
            res_sr  <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr  <= res_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          carry_r <= slice_c_out;
          cnt     <= cnt + CNT_W'(1);
          // Capture the final word on the last bit edge so y/c_out are
          // already valid while done is high.
          if (last_bit) begin
            y     <= res_next;
            c_out <= slice_c_out;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Scoreboard bench: directed ops push expected results, monitors pop on done.
module tb_bit_serial_alu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bench slice model: {c_out, result}
  function automatic logic [1:0] slice_f(input logic [2:0] o, input logic x, z, c);
    case (o)
      3'd2:    slice_f = {(x & z) | (x & c) | (z & c), x ^ z ^ c};
      3'd0:    slice_f = {c, x & z};
      3'd1:    slice_f = {c, x | z};
      default: slice_f = {c, 1'b0};
    endcase
  endfunction

  // WIDTH=8 instance
  logic       start8, cin8, sa8, sb8, sc8, sres8, sco8, busy8, done8, co8;
  logic [2:0] op8, sop8;
  logic [7:0] a8, b8, y8;
  assign {sco8, sres8} = slice_f(sop8, sa8, sb8, sc8);

  bit_serial_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .carry_init(cin8), .slice_a(sa8), .slice_b(sb8), .slice_c_in(sc8),
    .slice_op(sop8), .slice_result(sres8), .slice_c_out(sco8),
    .busy(busy8), .done(done8), .y(y8), .c_out(co8)
  );

  // WIDTH=1 instance
  logic       start1, cin1, sa1, sb1, sc1, sres1, sco1, busy1, done1, co1;
  logic [2:0] op1, sop1;
  logic [0:0] a1, b1, y1;
  assign {sco1, sres1} = slice_f(sop1, sa1, sb1, sc1);

  bit_serial_alu_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .carry_init(cin1), .slice_a(sa1), .slice_b(sb1), .slice_c_in(sc1),
    .slice_op(sop1), .slice_result(sres1), .slice_c_out(sco1),
    .busy(busy1), .done(done1), .y(y1), .c_out(co1)
  );

  typedef struct {
    logic [7:0] y;
    logic       c;
    int         due;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitors
  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("y8", {24'd0, y8}, {24'd0, e.y});
        chk("c_out8", {31'd0, co8}, {31'd0, e.c});
        chk("done8_cycle", cyc, e.due);
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) chk("done1_unexpected", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("y1", {31'd0, y1}, {31'd0, e.y[0]});
        chk("c_out1", {31'd0, co1}, {31'd0, e.c});
        chk("done1_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge (cycle cyc+1),
  // done is then seen after WIDTH more edges.
  task automatic issue8(input logic [2:0] o, input logic [7:0] xa, input logic [7:0] xb,
                        input logic ci, input logic [7:0] ey, input logic ec, input bit push);
    exp_t e;
    start8 = 1'b1; op8 = o; a8 = xa; b8 = xb; cin8 = ci;
    if (push) begin
      e.y = ey; e.c = ec; e.due = cyc + 1 + 8;
      q8.push_back(e);
    end
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic wait_idle8(output int n);
    n = 0;
    while (busy8 === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("busy8_timeout", 32'd1, 32'd0);
  endtask

  logic [7:0] a5_bits;
  int n;

  initial begin
    rst_n = 1'b0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; op1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    #12;
    chk("rst_busy8", {31'd0, busy8}, 0);
    chk("rst_done8", {31'd0, done8}, 0);
    chk("rst_y8", {24'd0, y8}, 0);
    chk("rst_slice8", {26'd0, sa8, sb8, sc8, sop8}, 0);
    chk("rst_y1", {30'd0, y1, co1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // add 3C+0F, latency and busy length
    issue8(3'd2, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b1);
    wait_idle8(n);
    chk("busy8_len", n, 9);

    // carry out of MSB
    issue8(3'd2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_idle8(n);
    issue8(3'd2, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
    wait_idle8(n);

    // AND with per-bit slice checks
    issue8(3'd0, 8'hA5, 8'h0F, 1'b0, 8'h05, 1'b0, 1'b1);
    a5_bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("slice_a8_bit%0d", i), {31'd0, sa8}, {31'd0, a5_bits[i]});
      chk("slice_op8", {29'd0, sop8}, 0);
      @(negedge clk);
    end
    wait_idle8(n);
    chk("idle_slice8", {26'd0, sa8, sb8, sc8, sop8}, 0);

    // stray start while busy, then back-to-back launch
    issue8(3'd2, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    start8 = 1'b1; op8 = 3'd0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8(n);
    issue8(3'd2, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_idle8(n);
    chk("y8_hold_after_done", {24'd0, y8}, 0);

    // reset mid-SHIFT at cnt=4
    issue8(3'd2, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy8", {31'd0, busy8}, 0);
    chk("mid_rst_done8", {31'd0, done8}, 0);
    chk("mid_rst_y8", {23'd0, y8, co8}, 0);
    chk("mid_rst_slice8", {26'd0, sa8, sb8, sc8, sop8}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue8(3'd2, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1);
    wait_idle8(n);

    // WIDTH=1 build
    begin
      exp_t e;
      start1 = 1'b1; op1 = 3'd2; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      e.y = 8'h01; e.c = 1'b1; e.due = cyc + 1 + 1;
      q1.push_back(e);
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", {31'd0, busy1}, 1);
      chk("w1_slice_a", {31'd0, sa1}, 1);
      repeat (4) @(negedge clk);
      chk("w1_idle", {31'd0, busy1}, 0);
    end

    repeat (5) @(negedge clk);
    chk("q8_drained", q8.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
